core_bus_port: RTL and testbench
================================

Name: core_bus_port

Overview:
Per-core bus master interface sitting directly upstream of the two-core bus arbiter; one instance per core.
Accepts core load/store requests, posts stores into a small write buffer, and serialises buffered writes and single reads onto the arbiter's request/grant interface.
Returns read data to the core with a one-cycle valid pulse.

Parameters:
WBUF_DEPTH, 4, write-buffer entries (power of two, >= 2)
ADDR_W, 9, RAM address width
DATA_W, 8, data width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
cpu_req_valid  in  1  core presents a request
cpu_req_ready  out  1  block accepts the request this cycle
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  request address
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data, valid with cpu_rvalid
cpu_rvalid  out  1  one-cycle read-response pulse
bus_request  out  1  request to arbiter
bus_grant  in  1  one-cycle grant pulse from arbiter; completes current transaction
bus_rw  out  1  1 = write, 0 = read
bus_address  out  ADDR_W  transaction address
bus_data_out  out  DATA_W  write data to arbiter
bus_data_in  in  DATA_W  read data from arbiter, sampled in the grant cycle
wbuf_count  out  $clog2(WBUF_DEPTH)+1  buffered write count

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; FIFO emptied; buffered writes discarded; read-pending cleared; bus FSM to B_IDLE. bus_request drops immediately, including mid-transaction.
- Accept: a request is accepted when cpu_req_valid && cpu_req_ready at a clock edge.
- Write ready: cpu_req_ready = !rd_pending && (count < WBUF_DEPTH).
  - A full buffer is not ready, even if a pop occurs in the same cycle.
- Read ready: cpu_req_ready = !rd_pending. An accepted read latches its address and sets rd_pending.
- Pushes and pops in the same cycle are both honoured; count is unchanged.
- Bus FSM, all bus outputs registered:
  - B_IDLE:
    - if rd_pending and FIFO empty -> B_READ
    - else if FIFO not empty -> B_WRITE
    - bus_request is 0 in B_IDLE.
  - B_WRITE: bus_request=1, bus_rw=1, address and data from FIFO head, held stable. On bus_grant: pop, -> B_IDLE.
  - B_READ: bus_request=1, bus_rw=0, bus_address = latched read address. On bus_grant: cpu_rdata <= bus_data_in; cpu_rvalid=1 on the next cycle only; clear rd_pending; -> B_IDLE.
- Ordering:
  - Reads never bypass older buffered writes; the buffer fully drains before a read is issued (RAW-safe).
  - Writes accepted after a read cannot occur, because the read blocks ready.
- Request is deasserted for at least one B_IDLE cycle between transactions, so the arbiter can rotate.
- Minimum read latency, empty buffer and immediate grant: accept edge N, bus_request high from N+1, grant at N+2, cpu_rvalid at N+3.
- The FIFO pointers wrap modulo WBUF_DEPTH. wbuf_count ranges 0..WBUF_DEPTH.
- A grant received in B_IDLE is ignored. This is an arbiter protocol error; the assertion flags it.

Optional Feature:
WBUF_FWD_EN:
- Defined: an accepted read is compared against all valid FIFO entries.
  - On a hit, cpu_rdata takes the youngest matching entry's data and cpu_rvalid pulses on the next cycle. No bus transaction, no drain, rd_pending is never set.
  - On a miss, the read drains and issues normally.
- Undefined: compare logic is absent; every read drains then goes to the bus.

Decomposition:
- Package bus_pkg:
  - ADDR_W/DATA_W defaults
  - typedef wbuf_entry_t {addr, data}
  - enum bus_state_t {B_IDLE, B_WRITE, B_READ}
  - rw encoding constants RW_READ=0, RW_WRITE=1
- Sub-module wbuf_fifo: the write-buffer storage and pointers, with push/pop/count/head, plus per-entry outputs for forwarding.

Test Plan:
1. Reset: hold reset=0 mid-B_WRITE with 2 entries buffered -> bus_request=0 immediately, wbuf_count=0, cpu_req_ready=1 after release.
2. Posted writes: 4 writes (0x010<-0xA1 .. 0x013<-0xA4), grant withheld -> 4 accepted, 5th blocked (ready=0). Grant every 3rd cycle -> bus sees addresses 0x010..0x013 in order, with a request gap between each.
3. Read after write: write 0x1FF<-0x5C, then read 0x1FF, arbiter returns 0x5C on grant -> write granted first, then read issued; cpu_rdata=0x5C, one-cycle cpu_rvalid.
4. Read latency: empty buffer, read 0x000, grant on the first request cycle, bus_data_in=0x3E -> cpu_rvalid exactly 3 cycles after accept, cpu_rdata=0x3E.
5. Simultaneous push/pop: count=2, write accepted in the same cycle as a grant -> count stays 2, FIFO order preserved across pointer wrap.
6. WBUF_FWD_EN: buffer 0x020<-0x11 then 0x020<-0x22, read 0x020 -> cpu_rdata=0x22 next cycle, no bus read. Without the macro -> drain, bus read, data taken from bus_data_in.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the per-core bus master port and its write buffer.
package bus_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 8;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wbuf_entry_t;

  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_WRITE = 2'd1,
    B_READ  = 2'd2
  } bus_state_t;

endpackage

// File: rtl/core_bus_port_if.sv
// Core-side request/response interface and arbiter-side request/grant interface.
interface cpu_req_if #(
  parameter int ADDR_W = bus_pkg::DEF_ADDR_W,
  parameter int DATA_W = bus_pkg::DEF_DATA_W
);
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  modport master (
    output cpu_req_valid, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_req_ready, cpu_rdata, cpu_rvalid
  );

  modport slave (
    input  cpu_req_valid, cpu_we, cpu_addr, cpu_wdata,
    output cpu_req_ready, cpu_rdata, cpu_rvalid
  );
endinterface

interface bus_req_if #(
  parameter int ADDR_W = bus_pkg::DEF_ADDR_W,
  parameter int DATA_W = bus_pkg::DEF_DATA_W
);
  logic              bus_request;
  logic              bus_grant;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_address;
  logic [DATA_W-1:0] bus_data_out;
  logic [DATA_W-1:0] bus_data_in;

  modport master (
    output bus_request, bus_rw, bus_address, bus_data_out,
    input  bus_grant, bus_data_in
  );

  modport slave (
    input  bus_request, bus_rw, bus_address, bus_data_out,
    output bus_grant, bus_data_in
  );
endinterface

// File: rtl/wbuf_fifo.sv
// Posted-write buffer: circular storage with push/pop/count/head.
// With WBUF_FWD_EN defined it also exposes every entry in age order (0 = oldest).
module wbuf_fifo
  import bus_pkg::*;
#(
  parameter int WBUF_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  wbuf_entry_t                   push_entry,
  input  logic                          pop,
  output wbuf_entry_t                   head,
  output logic [$clog2(WBUF_DEPTH):0]   count
`ifdef WBUF_FWD_EN
  ,
  output wbuf_entry_t                   age_entry [WBUF_DEPTH],
  output logic [WBUF_DEPTH-1:0]         age_valid
`endif
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbuf_entry_t      mem [WBUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage holds data only; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

`ifdef WBUF_FWD_EN
  always_comb begin
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      age_entry[i] = mem[rd_ptr + PTR_W'(i)];
      age_valid[i] = (CNT_W'(i) < count);
    end
  end
`endif

endmodule

// File: rtl/core_bus_port.sv
// Per-core bus master: posts stores into a write buffer, serialises writes and single reads
// onto the arbiter request/grant interface. Optional read forwarding from the buffer: WBUF_FWD_EN.
module core_bus_port
  import bus_pkg::*;
#(
  parameter int WBUF_DEPTH = 4,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  cpu_req_if.slave                    cpu,
  bus_req_if.master                   bus,
  output logic [$clog2(WBUF_DEPTH):0] wbuf_count
);

  localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

  bus_state_t        state, state_next;
  logic              rd_pending;
  logic [ADDR_W-1:0] rd_addr;
  logic              full, empty;
  logic              accept, push, pop, rd_acc, rd_grant;
  wbuf_entry_t       push_entry, head;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              vld_p0;
  logic [DATA_W-1:0] rdata_p0;

  logic              req_next, rw_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] data_next;

  assign full   = (wbuf_count == CNT_W'(WBUF_DEPTH));
  assign empty  = (wbuf_count == '0);

  // A full buffer refuses writes even when a pop lands in the same cycle.
  assign cpu.cpu_req_ready = !rd_pending && (!cpu.cpu_we || !full);

  assign accept     = cpu.cpu_req_valid && cpu.cpu_req_ready;
  assign push       = accept && cpu.cpu_we;
  assign rd_acc     = accept && !cpu.cpu_we;
  assign pop        = (state == B_WRITE) && bus.bus_grant;
  assign rd_grant   = (state == B_READ) && bus.bus_grant;
  assign push_entry = '{addr: cpu.cpu_addr, data: cpu.cpu_wdata};

`ifdef WBUF_FWD_EN
  wbuf_entry_t           age_entry [WBUF_DEPTH];
  logic [WBUF_DEPTH-1:0] age_valid;

  wbuf_fifo #(.WBUF_DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (wbuf_count),
    .age_entry  (age_entry),
    .age_valid  (age_valid)
  );

  // Scan oldest to youngest so the youngest matching store wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (age_valid[i] && (age_entry[i].addr == cpu.cpu_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = age_entry[i].data;
      end
    end
  end
`else
  wbuf_fifo #(.WBUF_DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (wbuf_count)
  );

  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pending <= 1'b0;
    end else if (rd_acc && !fwd_hit) begin
      rd_pending <= 1'b1;
    end else if (rd_grant) begin
      rd_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_acc) rd_addr <= cpu.cpu_addr;
  end

  // Bus FSM: IDLE always drops request, so every transaction is separated by an idle cycle.
  always_comb begin
    state_next = state;
    req_next   = bus.bus_request;
    rw_next    = bus.bus_rw;
    addr_next  = bus.bus_address;
    data_next  = bus.bus_data_out;
    case (state)
      B_IDLE: begin
        req_next = 1'b0;
        if (rd_pending && empty) begin
          state_next = B_READ;
          req_next   = 1'b1;
          rw_next    = RW_READ;
          addr_next  = rd_addr;
        end else if (!empty) begin
          state_next = B_WRITE;
          req_next   = 1'b1;
          rw_next    = RW_WRITE;
          addr_next  = head.addr;
          data_next  = head.data;
        end
      end
      B_WRITE, B_READ: begin
        if (bus.bus_grant) begin
          state_next = B_IDLE;
          req_next   = 1'b0;
        end
      end
      default: begin
        state_next = B_IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= B_IDLE;
      bus.bus_request  <= 1'b0;
      bus.bus_rw       <= 1'b0;
      bus.bus_address  <= '0;
      bus.bus_data_out <= '0;
    end else begin
      state            <= state_next;
      bus.bus_request  <= req_next;
      bus.bus_rw       <= rw_next;
      bus.bus_address  <= addr_next;
      bus.bus_data_out <= data_next;
    end
  end

  // p0: capture read data (bus grant or forward hit)
  always_ff @(posedge clk) begin
    if (rd_grant)               rdata_p0 <= bus.bus_data_in;
    else if (rd_acc && fwd_hit) rdata_p0 <= fwd_data;
  end

  // p1: present data with a one-cycle valid pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0         <= 1'b0;
      cpu.cpu_rvalid <= 1'b0;
      cpu.cpu_rdata  <= '0;
    end else begin
      vld_p0         <= rd_grant || (rd_acc && fwd_hit);
      cpu.cpu_rvalid <= vld_p0;
      if (vld_p0) cpu.cpu_rdata <= rdata_p0;
    end
  end

  // The arbiter must only grant while a request is outstanding.
  grant_in_idle: assert property (@(posedge clk) disable iff (!reset)
    !((state == B_IDLE) && bus.bus_grant));

endmodule

// File: tb/tb_core_bus_port.sv
// Bench for core_bus_port: directed scenarios plus a randomized phase checked against a RAM/queue model.
module tb_core_bus_port;
  import bus_pkg::*;

  localparam int WBUF_DEPTH = 4;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [$clog2(WBUF_DEPTH):0] wbuf_count;

  cpu_req_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu ();
  bus_req_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  core_bus_port #(.WBUF_DEPTH(WBUF_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (cpu),
    .bus        (bus),
    .wbuf_count (wbuf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] bus_mem [1 << ADDR_W];
  logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
  txn_t obs_q [$];
  txn_t exp_wr [$];

  int   grant_mode = 0;   // 0 never, 1 always, 2 every third cycle, 3 random, 4 forced
  logic force_grant = 1'b0;
  int   gap_err = 0;
  logic granted_last = 1'b0;
  int   arb_cyc = 0;

  // Arbiter model backed by bus_mem; logs every granted transaction.
  always @(negedge clk) begin
    logic g;
    txn_t t;
    if (granted_last && bus.bus_request) gap_err++;
    g = 1'b0;
    if (reset && bus.bus_request) begin
      case (grant_mode)
        1:       g = 1'b1;
        2:       g = (arb_cyc % 3 == 2);
        3:       g = 1'($urandom_range(0, 1));
        4:       g = force_grant;
        default: g = 1'b0;
      endcase
    end
    arb_cyc++;
    bus.bus_data_in = bus_mem[bus.bus_address];
    if (g) begin
      t.rw   = bus.bus_rw;
      t.addr = bus.bus_address;
      t.data = bus.bus_rw ? bus.bus_data_out : bus_mem[bus.bus_address];
      obs_q.push_back(t);
      if (bus.bus_rw) bus_mem[bus.bus_address] = bus.bus_data_out;
    end
    bus.bus_grant = g;
    granted_last  = g;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  task automatic req(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input int bound, output bit ok);
    txn_t t;
    cpu.cpu_req_valid = 1'b1;
    cpu.cpu_we        = we;
    cpu.cpu_addr      = a;
    cpu.cpu_wdata     = d;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (cpu.cpu_req_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      @(posedge clk);
      #1;
      if (we) begin
        ref_mem[a] = d;
        t.rw = 1'b1; t.addr = a; t.data = d;
        exp_wr.push_back(t);
      end
    end
    cpu.cpu_req_valid = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input string tag);
    bit ok;
    req(1'b1, a, d, 200, ok);
    check({tag, "_wr_accept"}, 32'(ok), 1);
  endtask

  task automatic wait_rvalid(output int n, input int bound);
    n = 0;
    while (n < bound) begin
      tick();
      n++;
      if (cpu.cpu_rvalid) return;
    end
    n = -1;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input string tag);
    bit ok;
    int n;
    logic [DATA_W-1:0] e;
    e = ref_mem[a];
    req(1'b0, a, '0, 200, ok);
    check({tag, "_rd_accept"}, 32'(ok), 1);
    wait_rvalid(n, 200);
    check({tag, "_rvalid_seen"}, 32'(n > 0), 1);
    check({tag, "_rdata"}, 32'(cpu.cpu_rdata), 32'(e));
    tick();
    check({tag, "_rvalid_pulse"}, 32'(cpu.cpu_rvalid), 0);
  endtask

  task automatic wait_empty(input int bound, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (wbuf_count == 0 && !bus.bus_request && !bus.bus_grant) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_drain_timeout"}, 32'(ok), 1);
  endtask

  task automatic check_txn(input string tag, input int idx, input logic rw,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (idx < obs_q.size()) begin
      check({tag, "_rw"},   32'(obs_q[idx].rw),   32'(rw));
      check({tag, "_addr"}, 32'(obs_q[idx].addr), 32'(a));
      if (rw) check({tag, "_data"}, 32'(obs_q[idx].data), 32'(d));
    end
  endtask

  initial begin
    int n;
    bit ok;
    txn_t wq [$];

    cpu.cpu_req_valid = 1'b0;
    cpu.cpu_we        = 1'b0;
    cpu.cpu_addr      = '0;
    cpu.cpu_wdata     = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      bus_mem[i] = DATA_W'($urandom);
      ref_mem[i] = bus_mem[i];
    end

    // Reset values
    tick(); tick();
    check("rst_request", 32'(bus.bus_request), 0);
    check("rst_count",   32'(wbuf_count), 0);
    check("rst_rvalid",  32'(cpu.cpu_rvalid), 0);
    check("rst_rdata",   32'(cpu.cpu_rdata), 0);
    check("rst_addr",    32'(bus.bus_address), 0);
    #3 reset = 1'b1;
    tick();
    check("rst_ready", 32'(cpu.cpu_req_ready), 1);

    // 1: reset in the middle of a buffered write
    grant_mode = 0;
    wr(9'h100, 8'h01, "t1");
    wr(9'h101, 8'h02, "t1");
    tick();
    check("t1_req_before", 32'(bus.bus_request), 1);
    check("t1_cnt_before", 32'(wbuf_count), 2);
    #2 reset = 1'b0;
    #1;
    check("t1_req_async", 32'(bus.bus_request), 0);
    check("t1_cnt_async", 32'(wbuf_count), 0);
    #3 reset = 1'b1;
    cpu.cpu_we = 1'b1;
    tick();
    check("t1_ready_after", 32'(cpu.cpu_req_ready), 1);
    tick();
    check("t1_req_after", 32'(bus.bus_request), 0);
    for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = bus_mem[i];
    obs_q.delete();
    exp_wr.delete();

    // 2: posted writes fill the buffer, then drain in order with gaps
    for (int i = 0; i < 4; i++) wr(9'h010 + ADDR_W'(i), 8'hA1 + DATA_W'(i), "t2");
    check("t2_count_full", 32'(wbuf_count), 4);
    cpu.cpu_req_valid = 1'b1; cpu.cpu_we = 1'b1; cpu.cpu_addr = 9'h014; cpu.cpu_wdata = 8'hA5;
    tick(); tick();
    check("t2_fifth_blocked", 32'(cpu.cpu_req_ready), 0);
    check("t2_count_held", 32'(wbuf_count), 4);
    cpu.cpu_req_valid = 1'b0;
    grant_mode = 2;
    wait_empty(100, "t2");
    check("t2_txn_count", 32'(obs_q.size()), 4);
    for (int i = 0; i < 4; i++)
      check_txn("t2_txn", i, 1'b1, 9'h010 + ADDR_W'(i), 8'hA1 + DATA_W'(i));
    check("t2_gap", 32'(gap_err), 0);
    obs_q.delete();

    // 3: read after write to the same address
    wr(9'h1FF, 8'h5C, "t3");
    do_read(9'h1FF, "t3");
    wait_empty(100, "t3");
`ifdef WBUF_FWD_EN
    check("t3_txn_count", 32'(obs_q.size()), 1);
    check_txn("t3_wr", 0, 1'b1, 9'h1FF, 8'h5C);
`else
    check("t3_txn_count", 32'(obs_q.size()), 2);
    check_txn("t3_wr", 0, 1'b1, 9'h1FF, 8'h5C);
    check_txn("t3_rd", 1, 1'b0, 9'h1FF, 8'h00);
`endif
    obs_q.delete();

    // 4: minimum read latency with an immediate grant
    grant_mode = 1;
    bus_mem[0] = 8'h3E;
    ref_mem[0] = 8'h3E;
    req(1'b0, 9'h000, '0, 10, ok);
    check("t4_accept", 32'(ok), 1);
    wait_rvalid(n, 20);
    check("t4_latency", 32'(n), 3);
    check("t4_rdata", 32'(cpu.cpu_rdata), 32'h3E);
    tick();
    check("t4_pulse", 32'(cpu.cpu_rvalid), 0);
    check("t4_txn_count", 32'(obs_q.size()), 1);
    check_txn("t4_rd", 0, 1'b0, 9'h000, 8'h00);
    obs_q.delete();

    // 5: push and pop in the same cycle, order kept across pointer wrap
    wait_empty(50, "t5a");
    grant_mode  = 4;
    force_grant = 1'b0;
    wr(9'h040, 8'hB0, "t5");
    wr(9'h041, 8'hB1, "t5");
    tick();
    check("t5_count_pre", 32'(wbuf_count), 2);
    check("t5_req_pre", 32'(bus.bus_request), 1);
    force_grant = 1'b1;
    wr(9'h042, 8'hB2, "t5");
    force_grant = 1'b0;
    check("t5_count_same", 32'(wbuf_count), 2);
    wr(9'h043, 8'hB3, "t5");
    wr(9'h044, 8'hB4, "t5");
    check("t5_count_full", 32'(wbuf_count), 4);
    grant_mode = 1;
    wait_empty(100, "t5b");
    check("t5_txn_count", 32'(obs_q.size()), 5);
    for (int i = 0; i < 5; i++)
      check_txn("t5_txn", i, 1'b1, 9'h040 + ADDR_W'(i), 8'hB0 + DATA_W'(i));
    obs_q.delete();

    // 6: read hitting two buffered stores to the same address
`ifdef WBUF_FWD_EN
    grant_mode = 0;
    wr(9'h020, 8'h11, "t6");
    wr(9'h020, 8'h22, "t6");
    req(1'b0, 9'h020, '0, 10, ok);
    check("t6_accept", 32'(ok), 1);
    tick();
    check("t6_fwd_rvalid", 32'(cpu.cpu_rvalid), 1);
    check("t6_fwd_rdata", 32'(cpu.cpu_rdata), 32'h22);
    tick();
    check("t6_fwd_pulse", 32'(cpu.cpu_rvalid), 0);
    check("t6_still_write", 32'(bus.bus_rw), 1);
    grant_mode = 1;
    wait_empty(100, "t6");
    check("t6_txn_count", 32'(obs_q.size()), 2);
`else
    grant_mode = 2;
    wr(9'h020, 8'h11, "t6");
    wr(9'h020, 8'h22, "t6");
    do_read(9'h020, "t6");
    wait_empty(100, "t6");
    check("t6_txn_count", 32'(obs_q.size()), 3);
    check_txn("t6_wr0", 0, 1'b1, 9'h020, 8'h11);
    check_txn("t6_wr1", 1, 1'b1, 9'h020, 8'h22);
    check_txn("t6_rd",  2, 1'b0, 9'h020, 8'h00);
`endif
    obs_q.delete();

    // Randomized traffic over a small address window
    grant_mode = 3;
    exp_wr.delete();
    for (int k = 0; k < 80; k++) begin
      logic [ADDR_W-1:0] a;
      a = 9'h080 + ADDR_W'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) wr(a, DATA_W'($urandom), "rnd");
      else do_read(a, "rnd");
    end
    wait_empty(300, "rnd");
    foreach (obs_q[i]) if (obs_q[i].rw) wq.push_back(obs_q[i]);
    check("rnd_wr_count", 32'(wq.size()), 32'(exp_wr.size()));
    for (int i = 0; i < wq.size() && i < exp_wr.size(); i++) begin
      check("rnd_wr_addr", 32'(wq[i].addr), 32'(exp_wr[i].addr));
      check("rnd_wr_data", 32'(wq[i].data), 32'(exp_wr[i].data));
    end
    for (int i = 9'h080; i < 9'h086; i++)
      check("rnd_mem", 32'(bus_mem[i]), 32'(ref_mem[i]));
    check("rnd_gap", 32'(gap_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
